// File: rtl/flash_loader.sv
// flash_loader: streams an image from SPI flash (READ 0x03, mode 0) to a byte download port.
// Define FLASH_LOADER_HDR_CHECK_EN to reject images whose first bytes are not 4E 45 53 1A.
module flash_loader #(
    parameter int CLK_DIV = 2,
    parameter int TAIL    = 2
) (
    input  logic        I_CLK,
    input  logic        I_RESET_N,
    input  logic        I_START,
    input  logic [23:0] I_FLASH_ADDR,
    input  logic [21:0] I_LENGTH,
    input  logic        I_SPI_MISO,
    output logic        O_SPI_CLK,
    output logic        O_SPI_MOSI,
    output logic        O_SPI_CS_N,
    output logic [7:0]  O_DOWNLOAD_DO,
    output logic        O_DOWNLOAD_WR,
    output logic        O_DOWNLOAD_ON,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_ERROR
);
`ifdef FLASH_LOADER_HDR_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_TAIL, S_FINISH, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_TAIL, S_FINISH} state_t;
`endif
    state_t      state_q, state_d;
    logic [3:0]  div_q, div_d;
    logic        sck_q, sck_d, cs_n_q, cs_n_d, rdy_q, rdy_d, wr_q, wr_d;
    logic        on_q, on_d, busy_q, busy_d, done_q, done_d;
    logic [31:0] sr_q, sr_d;
    logic [4:0]  bit_q, bit_d;
    logic [7:0]  rx_q, rx_d, do_q, do_d, tail_q, tail_d;
    logic [21:0] rem_q, rem_d;
    logic        tick, rise, fall;
`ifdef FLASH_LOADER_HDR_CHECK_EN
    logic        err_q, err_d, bad;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  hdr_b;
    assign hdr_b = idx_q[1:0] == 2'd0 ? 8'h4E : idx_q[1:0] == 2'd1 ? 8'h45 :
                   idx_q[1:0] == 2'd2 ? 8'h53 : 8'h1A;
    assign bad   = !idx_q[2] && rx_q != hdr_b;
`endif

    assign tick = div_q == 4'(CLK_DIV - 1);
    assign rise = (state_q == S_CMD || state_q == S_DATA) && tick && !sck_q;
    assign fall = (state_q == S_CMD || state_q == S_DATA) && tick && sck_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        rdy_d   = 1'b0;
        rem_d   = rem_q;
        tail_d  = tail_q;
        do_d    = do_q;
        wr_d    = 1'b0;
        on_d    = on_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef FLASH_LOADER_HDR_CHECK_EN
        err_d   = err_q;
        idx_d   = idx_q;
`endif
        if (state_q == S_CMD || state_q == S_DATA) begin
            div_d = tick ? 4'd0 : div_q + 4'd1;
            sck_d = tick ? ~sck_q : sck_q;
            if (rise) begin
                rx_d  = {rx_q[6:0], I_SPI_MISO};
                bit_d = bit_q + 5'd1;
            end
            // zero-fill makes MOSI fall to 0 on the SCK fall after the last address bit
            if (fall)
                sr_d = {sr_q[30:0], 1'b0};
        end
        case (state_q)
            S_IDLE: if (I_START && I_LENGTH != '0) begin
                state_d = S_CMD;
                busy_d  = 1'b1;
                on_d    = 1'b1;
                cs_n_d  = 1'b0;
                done_d  = 1'b0;
                sr_d    = {8'h03, I_FLASH_ADDR};
                rem_d   = I_LENGTH;
                div_d   = 4'd0;
                sck_d   = 1'b0;
                bit_d   = 5'd0;
`ifdef FLASH_LOADER_HDR_CHECK_EN
                err_d   = 1'b0;
                idx_d   = 3'd0;
`endif
            end
            S_CMD: if (rise && bit_q == 5'd31)
                state_d = S_DATA;
            S_DATA: begin
                if (rise && bit_q[2:0] == 3'd7)
                    rdy_d = 1'b1;
`ifdef FLASH_LOADER_HDR_CHECK_EN
                if (rdy_q && bad) begin
                    state_d = S_ERR;
                    sck_d   = 1'b0;
                end else
`endif
                if (rdy_q) begin
                    do_d  = rx_q;
                    wr_d  = 1'b1;
                    rem_d = rem_q - 22'd1;
`ifdef FLASH_LOADER_HDR_CHECK_EN
                    idx_d = idx_q + {2'b0, ~idx_q[2]};
`endif
                    // last byte: park SCK low now so CS_N can rise on the following edge
                    if (rem_q == 22'd1) begin
                        state_d = S_TAIL;
                        sck_d   = 1'b0;
                        tail_d  = 8'(TAIL);
                    end
                end
            end
            S_TAIL: begin
                cs_n_d = 1'b1;
                if (tail_q <= 8'd1) begin
                    on_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else
                    tail_d = tail_q - 8'd1;
            end
            S_FINISH: state_d = S_IDLE;
`ifdef FLASH_LOADER_HDR_CHECK_EN
            S_ERR: begin
                cs_n_d = 1'b1;
                if (cs_n_q) begin
                    on_d    = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q <= S_IDLE;
            div_q   <= 4'd0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sr_q    <= 32'd0;
            bit_q   <= 5'd0;
            rx_q    <= 8'd0;
            rdy_q   <= 1'b0;
            rem_q   <= 22'd0;
            tail_q  <= 8'd0;
            do_q    <= 8'd0;
            wr_q    <= 1'b0;
            on_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FLASH_LOADER_HDR_CHECK_EN
            err_q   <= 1'b0;
            idx_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            rdy_q   <= rdy_d;
            rem_q   <= rem_d;
            tail_q  <= tail_d;
            do_q    <= do_d;
            wr_q    <= wr_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FLASH_LOADER_HDR_CHECK_EN
            err_q   <= err_d;
            idx_q   <= idx_d;
`endif
        end
    end

    assign O_SPI_CLK     = sck_q;
    assign O_SPI_MOSI    = sr_q[31];
    assign O_SPI_CS_N    = cs_n_q;
    assign O_DOWNLOAD_DO = do_q;
    assign O_DOWNLOAD_WR = wr_q;
    assign O_DOWNLOAD_ON = on_q;
    assign O_BUSY        = busy_q;
    assign O_DONE        = done_q;
`ifdef FLASH_LOADER_HDR_CHECK_EN
    assign O_ERROR       = err_q;
`else
    assign O_ERROR       = 1'b0;
`endif
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: flash model plus scoreboard for flash_loader; expected bytes come from an image function.
module tb_flash_loader;
    localparam int CLK_DIV = 2;
    localparam int TAIL    = 2;
    localparam int T       = 10;

    logic        I_CLK = 1'b0, I_RESET_N = 1'b1, I_START = 1'b0, I_SPI_MISO = 1'b0;
    logic [23:0] I_FLASH_ADDR = '0;
    logic [21:0] I_LENGTH = '0;
    logic        O_SPI_CLK, O_SPI_MOSI, O_SPI_CS_N, O_DOWNLOAD_WR, O_DOWNLOAD_ON, O_BUSY, O_DONE, O_ERROR;
    logic [7:0]  O_DOWNLOAD_DO;

    flash_loader #(.CLK_DIV(CLK_DIV), .TAIL(TAIL)) dut (
        .I_CLK(I_CLK), .I_RESET_N(I_RESET_N), .I_START(I_START), .I_FLASH_ADDR(I_FLASH_ADDR),
        .I_LENGTH(I_LENGTH), .I_SPI_MISO(I_SPI_MISO), .O_SPI_CLK(O_SPI_CLK), .O_SPI_MOSI(O_SPI_MOSI),
        .O_SPI_CS_N(O_SPI_CS_N), .O_DOWNLOAD_DO(O_DOWNLOAD_DO), .O_DOWNLOAD_WR(O_DOWNLOAD_WR),
        .O_DOWNLOAD_ON(O_DOWNLOAD_ON), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERROR(O_ERROR));

    always #(T/2) I_CLK = ~I_CLK;

    typedef struct {logic err; int n;} end_t;
    int          tests = 0, fails = 0, n_acc = 0, n_end = 0, nstb = 0, fcnt = 0, cs_cyc = 0, k;
    logic [7:0]  ovr [int];
    logic [7:0]  exp_q [$];
    logic [31:0] cmd_q [$];
    end_t        end_q [$];
    end_t        e;
    logic [31:0] fcmd = '0;
    logic [7:0]  fb;
    logic        pon = 1'b0, psck = 1'b0, last_err = 1'b0;
    time         last_wr = 0;
`ifdef FLASH_LOADER_HDR_CHECK_EN
    logic [7:0]  hdr [4] = '{8'h4E, 8'h45, 8'h53, 8'h1A};
`endif

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        if (ovr.exists(int'(a))) return ovr[int'(a)];
        return a[7:0] + 8'(a[15:8] * 7);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Flash device and download-port monitor, both sampled mid-cycle.
    always @(negedge I_CLK) begin
        if (!I_RESET_N) begin
            exp_q.delete(); end_q.delete(); cmd_q.delete();
            n_end = n_acc; nstb = 0; pon = 1'b0;
        end else begin
            if (O_SPI_CS_N) begin
                fcnt = 0; cs_cyc = 0;
            end else begin
                cs_cyc++;
                if (O_SPI_CLK && !psck) begin
                    if (fcnt == 0 && cs_cyc - 1 < CLK_DIV) fail("cs_setup");
                    if (fcnt < 32) begin
                        fcmd = {fcmd[30:0], O_SPI_MOSI};
                        if (fcnt == 31) begin
                            if (cmd_q.size() == 0) fail("cmd_unexpected");
                            else chk("cmd", fcmd, cmd_q.pop_front());
                        end
                    end else
                        chk("mosi_idle", O_SPI_MOSI, 1'b0);
                    fcnt++;
                end
                if (!O_SPI_CLK && psck && fcnt >= 32) begin
                    k = fcnt - 32;
                    fb = fbyte(fcmd[23:0] + 24'(k / 8));
                    I_SPI_MISO = fb[7 - k % 8];
                end
            end
            if (O_DOWNLOAD_WR) begin
                if (!O_DOWNLOAD_ON) fail("wr_without_on");
                if (nstb > 0) chk("strobe_gap", $time - last_wr, 64'(16 * CLK_DIV * T));
                if (exp_q.size() == 0) fail("strobe_unexpected");
                else chk("byte", O_DOWNLOAD_DO, exp_q.pop_front());
                nstb++;
                last_wr = $time;
            end
            if (pon && !O_DOWNLOAD_ON) begin
                if (end_q.size() == 0) fail("end_unexpected");
                else begin
                    e = end_q.pop_front();
                    chk("end_flags", {O_ERROR, O_DONE, O_BUSY}, {e.err, !e.err, 1'b0});
                    chk("strobe_count", nstb, e.n);
                    if (!e.err) chk("tail", $time - last_wr, 64'(TAIL * T));
                end
                n_end++;
                nstb = 0;
            end
            pon = O_DOWNLOAD_ON;
        end
        psck = O_SPI_CLK;
    end

    task automatic start(input logic [23:0] a, input int len);
        logic [7:0] b;
        int n;
        logic err;
        @(negedge I_CLK);
        I_START = 1'b1; I_FLASH_ADDR = a; I_LENGTH = 22'(len);
        if (len != 0 && n_acc == n_end) begin
            n = 0; err = 1'b0;
            cmd_q.push_back({8'h03, a});
            for (int i = 0; i < len; i++) begin
                b = fbyte(a + 24'(i));
`ifdef FLASH_LOADER_HDR_CHECK_EN
                if (i < 4 && b != hdr[i]) begin err = 1'b1; break; end
`endif
                exp_q.push_back(b);
                n++;
            end
            end_q.push_back('{err, n});
            n_acc++;
            last_err = err;
        end
        @(negedge I_CLK);
        I_START = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && n_acc != n_end; i++) @(negedge I_CLK);
        if (n_acc != n_end) fail("load_timeout");
        repeat (3) @(negedge I_CLK);
        chk("idle_flags", {O_BUSY, O_DONE, O_ERROR, O_SPI_CS_N, O_DOWNLOAD_ON},
            {1'b0, !last_err, last_err, 1'b1, 1'b0});
    endtask

    initial begin
        #(T * 90000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cs_seen;
        ovr[32'h200000] = 8'h4E; ovr[32'h200001] = 8'h45; ovr[32'h200002] = 8'h58;
        ovr[32'h300000] = 8'h4E; ovr[32'h300001] = 8'h45; ovr[32'h300002] = 8'h53; ovr[32'h300003] = 8'h1A;
        ovr[32'h400000] = 8'h4E; ovr[32'h400001] = 8'h45;
        #2 I_RESET_N = 1'b0;
        #1 chk("reset_vals", {O_SPI_CS_N, O_SPI_CLK, O_SPI_MOSI, O_DOWNLOAD_DO, O_DOWNLOAD_WR,
                              O_DOWNLOAD_ON, O_BUSY, O_DONE, O_ERROR}, {3'b100, 8'h00, 5'b0});
        repeat (3) @(negedge I_CLK);
        I_RESET_N = 1'b1;

        start(24'h100000, 16);
        @(negedge I_CLK);
        chk("accept_flags", {O_BUSY, O_DOWNLOAD_ON, O_SPI_CS_N, O_DONE, O_ERROR}, 5'b11000);
        wait_idle();

        start(24'h123456, 0);
        cs_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge I_CLK);
            cs_seen |= !O_SPI_CS_N || O_BUSY;
        end
        chk("len0_ignored", cs_seen, 1'b0);

        start(24'h100000, 16);
        repeat (60) @(negedge I_CLK);
        start(24'h555555, 8);
        wait_idle();

        start(24'h100000, 16);
        for (int i = 0; i < 3000 && nstb < 5; i++) @(posedge I_CLK);
        #1 I_RESET_N = 1'b0;
        #1 chk("abort_vals", {O_SPI_CS_N, O_SPI_CLK, O_SPI_MOSI, O_DOWNLOAD_DO, O_DOWNLOAD_WR,
                              O_DOWNLOAD_ON, O_BUSY, O_DONE, O_ERROR}, {3'b100, 8'h00, 5'b0});
        repeat (2) @(negedge I_CLK);
        I_RESET_N = 1'b1;
        repeat (150) @(negedge I_CLK);
        chk("after_abort", {O_SPI_CS_N, O_BUSY, O_DONE, O_DOWNLOAD_ON}, 4'b1000);

        start(24'h200000, 8); wait_idle();
        start(24'h300000, 8); wait_idle();
        start(24'h400000, 2); wait_idle();
        start(24'hFFFFFF, 1); wait_idle();
        for (int j = 0; j < 6; j++) begin
            start(24'($urandom), int'($urandom_range(24, 1)));
            wait_idle();
        end
        start(24'h300000, 5); wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
